// File: rtl/uart_alu_if.sv
// Serial-command ALU controller: pops operand A, operand B and an opcode from the
// UART receive FIFO, executes one ALU operation and pushes the result byte to the transmit FIFO.
module uart_alu_if #(
  parameter int N_BIT = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rx_empty,
  input  logic [N_BIT-1:0] r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [N_BIT-1:0] w_data,
  output logic             wr_uart,
  output logic             busy,
  output logic             bad_op
);

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  localparam logic [N_BIT-1:0] OP_ADD = N_BIT'(8'h20);
  localparam logic [N_BIT-1:0] OP_SUB = N_BIT'(8'h22);
  localparam logic [N_BIT-1:0] OP_AND = N_BIT'(8'h24);
  localparam logic [N_BIT-1:0] OP_OR  = N_BIT'(8'h25);
  localparam logic [N_BIT-1:0] OP_XOR = N_BIT'(8'h26);
  localparam logic [N_BIT-1:0] OP_NOR = N_BIT'(8'h27);
  localparam logic [N_BIT-1:0] OP_SRL = N_BIT'(8'h02);
  localparam logic [N_BIT-1:0] OP_SRA = N_BIT'(8'h03);
  localparam logic [N_BIT-1:0] SHIFT_LIMIT = N_BIT'(N_BIT);

  state_t           state_r, state_s;
  logic [N_BIT-1:0] a_r, b_r, op_r, result_r;
  logic             bad_op_r;
  logic [N_BIT-1:0] alu_result_s;
  logic             alu_bad_s;
  logic             rd_s, wr_s;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_GET_A;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and FIFO strobe logic; pops are gated off while reset is held
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    case (state_r)
      ST_GET_A, ST_GET_B, ST_GET_OP: begin
        rd_s = ~rx_empty & ~RESET;
        if (rd_s) begin
          if (state_r == ST_GET_A) begin
            state_s = ST_GET_B;
          end else if (state_r == ST_GET_B) begin
            state_s = ST_GET_OP;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_EXEC: begin
        state_s = ST_SEND;
      end
      ST_SEND: begin
        wr_s = ~tx_full & ~RESET;
        if (wr_s) begin
          state_s = ST_GET_A;
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s = ST_GET_A;
      end
    endcase
  end

  // ALU: shift amounts use the full unsigned value of B
  always_comb begin
    alu_result_s = '0;
    alu_bad_s    = 1'b0;
    case (op_r)
      OP_ADD: alu_result_s = a_r + b_r;
      OP_SUB: alu_result_s = a_r - b_r;
      OP_AND: alu_result_s = a_r & b_r;
      OP_OR:  alu_result_s = a_r | b_r;
      OP_XOR: alu_result_s = a_r ^ b_r;
      OP_NOR: alu_result_s = ~(a_r | b_r);
      OP_SRL: begin
        if (b_r >= SHIFT_LIMIT) begin
          alu_result_s = '0;
        end else begin
          alu_result_s = a_r >> b_r;
        end
      end
      OP_SRA: begin
        if (b_r >= SHIFT_LIMIT) begin
          alu_result_s = {N_BIT{a_r[N_BIT-1]}};
        end else begin
          alu_result_s = $unsigned($signed(a_r) >>> b_r);
        end
      end
      default: begin
        alu_result_s = '0;
        alu_bad_s    = 1'b1;
      end
    endcase
  end

  // Operand capture on pops, result and bad_op capture in EXEC
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= '0;
      result_r <= '0;
      bad_op_r <= 1'b0;
    end else begin
      if (rd_s && state_r == ST_GET_A)  a_r  <= r_data;
      if (rd_s && state_r == ST_GET_B)  b_r  <= r_data;
      if (rd_s && state_r == ST_GET_OP) op_r <= r_data;
      if (state_r == ST_EXEC) begin
        result_r <= alu_result_s;
        bad_op_r <= alu_bad_s;
      end
    end
  end

  assign rd_uart = rd_s;
  assign wr_uart = wr_s;
  assign w_data  = result_r;
  assign bad_op  = bad_op_r;
  assign busy    = (state_r != ST_GET_A);

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: queue-based FIFO model around the DUT, directed and
// randomized commands checked against an arithmetic ALU reference.
module tb_uart_alu_if;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       busy;
  logic       bad_op;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] rx_q[$];

  uart_alu_if #(.N_BIT(8)) dut (
    .CLK(CLK), .RESET(RESET), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .busy(busy), .bad_op(bad_op)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input int a, input int b, input int op, output logic bad);
    int sa;
    bad = 1'b0;
    case (op)
      32'h20: return 8'((a + b) % 256);
      32'h22: return 8'((a - b + 256) % 256);
      32'h24: return 8'(a & b);
      32'h25: return 8'(a | b);
      32'h26: return 8'(a ^ b);
      32'h27: return 8'(255 - (a | b));
      32'h02: return (b >= 8) ? 8'h00 : 8'(a / (1 << b));
      32'h03: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) return (sa < 0) ? 8'hFF : 8'h00;
        return 8'((sa >>> b) & 255);
      end
      default: begin
        bad = 1'b1;
        return 8'h00;
      end
    endcase
  endfunction

  // One full command: bytes a,b,op with `gap` forced-empty cycles after each pop,
  // and tx_full held for `hold` cycles starting right after the opcode pop.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input int hold, input bit chk_lat);
    logic [7:0] exp_w, got_w;
    logic       exp_bad, got_bad;
    int pops = 0, pushes = 0, first_pop = -1, push_cyc = -1, gap_cnt = 0, hold_left = hold;
    exp_w = ref_alu(int'(a), int'(b), int'(op), exp_bad);
    got_w = 8'h00;
    got_bad = 1'b0;
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
    for (int k = 0; k < 300 && pushes == 0; k++) begin
      @(negedge CLK);
      tx_full  = (pops == 3 && hold_left > 0);
      rx_empty = (gap_cnt > 0) || (rx_q.size() == 0);
      r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      #1;
      chk("rd_uart", 32'(rd_uart), 32'(!rx_empty && pops < 3));
      chk("busy", 32'(busy), 32'(pops != 0));
      if (tx_full) chk("wr_blocked", 32'(wr_uart), 32'd0);
      if (wr_uart) begin
        pushes++;
        push_cyc = cyc;
        got_w = w_data;
        got_bad = bad_op;
      end
      if (rd_uart) begin
        if (first_pop < 0) first_pop = cyc;
        void'(rx_q.pop_front());
        pops++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      if (tx_full) hold_left--;
      cyc++;
    end
    chk("push_count", 32'(pushes), 32'd1);
    chk("pop_count", 32'(pops), 32'd3);
    chk("w_data", 32'(got_w), 32'(exp_w));
    chk("bad_op", 32'(got_bad), 32'(exp_bad));
    if (chk_lat) chk("latency", 32'(push_cyc - first_pop), 32'd4);
    @(negedge CLK);
    tx_full  = 1'b0;
    rx_empty = 1'b1;
    #1;
    chk("no_dup_push", 32'(wr_uart), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    cyc++;
  endtask

  initial begin
    int pops;
    logic [7:0] ops[10];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h00, 8'h21};

    RESET = 1'b1;
    rx_empty = 1'b0;
    r_data = 8'hAA;
    tx_full = 1'b0;
    #1;
    chk("rst_rd_uart", 32'(rd_uart), 32'd0);
    chk("rst_wr_uart", 32'(wr_uart), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bad_op", 32'(bad_op), 32'd0);
    repeat (2) @(negedge CLK);
    rx_empty = 1'b1;
    RESET = 1'b0;

    // Directed commands
    run_cmd(8'h05, 8'h03, 8'h20, 0, 0, 1'b1);
    run_cmd(8'h03, 8'h05, 8'h22, 0, 0, 1'b1);
    run_cmd(8'h80, 8'h02, 8'h03, 0, 0, 1'b0);
    run_cmd(8'h80, 8'h02, 8'h02, 0, 0, 1'b0);
    run_cmd(8'h80, 8'h09, 8'h03, 0, 0, 1'b0);
    run_cmd(8'h80, 8'h09, 8'h02, 0, 0, 1'b0);
    run_cmd(8'h12, 8'h34, 8'hFF, 0, 0, 1'b0);
    run_cmd(8'hF0, 8'h0F, 8'h27, 0, 0, 1'b0);
    run_cmd(8'hC3, 8'h5A, 8'h26, 0, 11, 1'b0);
    run_cmd(8'h0C, 8'h0A, 8'h24, 7, 0, 1'b0);

    // Reset after A and B have been popped
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    pops = 0;
    for (int k = 0; k < 20 && pops < 2; k++) begin
      @(negedge CLK);
      rx_empty = (rx_q.size() == 0);
      r_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      #1;
      if (rd_uart) begin
        void'(rx_q.pop_front());
        pops++;
      end
    end
    chk("mid_pops", 32'(pops), 32'd2);
    @(negedge CLK);
    rx_empty = 1'b0;
    r_data = 8'h20;
    RESET = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd", 32'(rd_uart), 32'd0);
    chk("mid_rst_w_data", 32'(w_data), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      #1;
      chk("mid_rst_wr", 32'(wr_uart), 32'd0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    rx_empty = 1'b1;
    rx_q.delete();
    run_cmd(8'h01, 8'h01, 8'h20, 0, 0, 1'b1);

    // Randomized commands
    for (int n = 0; n < 24; n++) begin
      run_cmd(8'($urandom), ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom),
              ops[$urandom_range(0, 9)], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_if.md
# uart_alu_if

Host-side controller for the UART block. It drains the UART receive FIFO through its `rx_empty`/`r_data`/`rd_uart` interface and collects an operand A, an operand B and an opcode. It executes one ALU operation and pushes the result byte into the UART transmit FIFO through `tx_full`/`w_data`/`wr_uart`. This completes the serial-command ALU loop at the top level.

## Interface
- `N_BIT`, 8, data width of operands, opcode, result and both FIFO data ports.
- `CLK`  in  1  system clock, all state on rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `rx_empty`  in  1  UART receive FIFO empty flag.
- `r_data`  in  N_BIT  receive FIFO head word, valid whenever `rx_empty`=0.
- `rd_uart`  out  1  receive FIFO pop strobe, one cycle per byte.
- `tx_full`  in  1  UART transmit FIFO full flag.
- `w_data`  out  N_BIT  byte to push into the transmit FIFO.
- `wr_uart`  out  1  transmit FIFO push strobe, one cycle per result.
- `busy`  out  1  high whenever the FSM is not in GET_A.
- `bad_op`  out  1  last executed opcode was unsupported.

## Operation
- FSM states, in order: GET_A, GET_B, GET_OP, EXEC, SEND. Reset state is GET_A.
- GET_x states (x = A, B, OP):
  - `rd_uart` = (state is GET_x) & ~`rx_empty`, combinational.
  - On an edge with `rd_uart`=1: `r_data` is latched into the x register and the FSM advances to the next state.
  - With `rx_empty`=1: hold the state, `rd_uart`=0.
- EXEC: lasts exactly one cycle. The result register and `bad_op` are loaded from A, B and OP. The FSM goes to SEND.
- SEND:
  - `wr_uart` = (state is SEND) & ~`tx_full`, combinational.
  - On an edge with `wr_uart`=1, go to GET_A.
  - With `tx_full`=1: hold the state, `wr_uart`=0, result register unchanged.
- `w_data` is always driven from the result register.
- Opcodes (OP value → result, computed at N_BIT width):
  - 0x20 ADD: A+B, wraps mod 2^N_BIT.
  - 0x22 SUB: A−B, wraps mod 2^N_BIT.
  - 0x24 AND: A&B.
  - 0x25 OR: A|B.
  - 0x26 XOR: A^B.
  - 0x27 NOR: ~(A|B).
  - 0x02 SRL: A logical right shift by the full unsigned value of B. B ≥ N_BIT gives 0.
  - 0x03 SRA: A arithmetic right shift by the full unsigned value of B, with A treated as signed. B ≥ N_BIT gives all copies of A[N_BIT-1].
  - Any other value: result 0, `bad_op`=1.
- `bad_op` is rewritten at every EXEC: 1 for an unsupported opcode, 0 otherwise.
- No carry or overflow flags are produced.

## Timing
- Reset values:
  - State GET_A.
  - A, B, OP and result registers all 0; `w_data`=0.
  - `bad_op`=0, `busy`=0.
  - `rd_uart`=0 and `wr_uart`=0 while RESET is high.
- Pop handshake: the FIFO updates `r_data`/`rx_empty` on the same edge that samples `rd_uart`. The FSM never issues two pops in consecutive cycles for the same state, because the state advances on every pop.
- Back-to-back pops are legal. With a pre-loaded FIFO, A, B and OP are popped on three consecutive edges.
- Latency:
  - EXEC is the cycle after the OP pop edge.
  - `wr_uart` rises in the cycle after EXEC if `tx_full`=0.
  - Minimum command-to-push latency is 5 cycles from the first pop cycle (3 pop cycles, EXEC, push).
- The next command's GET_A starts the cycle after the push edge. Minimum throughput is one result per 5 cycles.
- Reset mid-operation returns to GET_A immediately (asynchronous). Bytes already popped are discarded, and no partial result is pushed.
- `tx_full` rising while in GET_x or EXEC has no effect until SEND.
- `rx_empty` toggling during EXEC or SEND is ignored; no pops occur there.

## Test plan
- FIFO preloaded with 0x05, 0x03, 0x20 → pops on 3 consecutive cycles; 2 cycles later `wr_uart` pulses once with `w_data`=0x08, `bad_op`=0.
- Bytes 0x03, 0x05, 0x22 → `w_data`=0xFE. Bytes 0x80, 0x02, 0x03 → 0xE0. Bytes 0x80, 0x02, 0x02 → 0x20. Bytes 0x80, 0x09, 0x03 → 0xFF.
- Bytes 0x12, 0x34, 0xFF → `w_data`=0x00, `bad_op`=1. A following 0xF0, 0x0F, 0x27 → 0x00 with `bad_op`=0.
- Hold `tx_full`=1 for 10 cycles after EXEC → `wr_uart` stays 0, `busy`=1. Release → exactly one `wr_uart` pulse with the unchanged result.
- Bytes delivered with 7 empty cycles between each → `rd_uart` only while `rx_empty`=0, exactly 3 pops, correct result.
- Assert RESET after A and B are popped → `busy`=0, no push. The next 0x01, 0x01, 0x20 yields 0x02.
